// File: rtl/fact_gpio_responder_pkg.sv
// rtl/fact_gpio_responder_pkg.sv - shared types, defaults and status packing for the factorial responder
package fact_gpio_responder_pkg;

  localparam int CNT_W_DEF   = 4;
  localparam int RES_W_DEF   = 29;
  localparam int GO_BIT_DEF  = 4;
  localparam int RES_FIELD_W = 29;

  localparam int ST_DONE_BIT = 31;
  localparam int ST_ERR_BIT  = 30;
  localparam int ST_BUSY_BIT = 29;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_MUL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [31:0] pack_status(input logic done, input logic err, input logic busy,
                                              input logic [RES_FIELD_W-1:0] res);
    logic [31:0] s;
    s = {{(32 - RES_FIELD_W){1'b0}}, res};
    s[ST_DONE_BIT] = done;
    s[ST_ERR_BIT]  = err;
    s[ST_BUSY_BIT] = busy;
    return s;
  endfunction

endpackage

// File: rtl/fact_gpio_responder_if.sv
// rtl/fact_gpio_responder_if.sv - CPU general-purpose port pair: command out, status back
interface fact_gpio_responder_if;

  logic [31:0] gp_cmd;
  logic [31:0] gp_status;

  modport master (output gp_cmd, input gp_status);
  modport slave  (input gp_cmd, output gp_status);

endinterface

// File: rtl/fact_gpio_responder_mul_shift_add.sv
// rtl/fact_gpio_responder_mul_shift_add.sv - sequential shift-add multiplier, one multiplier bit per cycle
// The start cycle performs the first step, so valid rises exactly CNT_W cycles after start.
module mul_shift_add #(
  parameter int RES_W = 29,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [RES_W-1:0] a_i,
  input  logic [CNT_W-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [RES_W-1:0] product_o,
  output logic             ovf_o
);

  localparam int FULL_W = RES_W + CNT_W;
  localparam int CW     = $clog2(CNT_W + 1);

  logic [FULL_W-1:0] mcand_q, sum_q;
  logic [CNT_W-1:0]  mplier_q;
  logic [CW-1:0]     cnt_q;
  logic              busy_q, valid_q;

  logic [FULL_W-1:0] mcand_d, sum_d;
  logic [CNT_W-1:0]  mplier_d;
  logic [CW-1:0]     cnt_d;

  always_comb begin
    mcand_d  = start_i ? FULL_W'(a_i) : mcand_q;
    mplier_d = start_i ? b_i : mplier_q;
    sum_d    = start_i ? '0 : sum_q;
    cnt_d    = start_i ? CW'(1) : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      sum_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start_i || busy_q) begin
        sum_q    <= sum_d + (mplier_d[0] ? mcand_d : '0);
        mcand_q  <= mcand_d << 1;
        mplier_q <= mplier_d >> 1;
        cnt_q    <= cnt_d;
        busy_q   <= (cnt_d != CW'(CNT_W));
        valid_q  <= (cnt_d == CW'(CNT_W));
      end
    end
  end

  assign busy_o    = busy_q;
  assign valid_o   = valid_q;
  assign product_o = sum_q[RES_W-1:0];
  assign ovf_o     = |sum_q[FULL_W-1:RES_W];

endmodule

// File: rtl/fact_gpio_responder.sv
// rtl/fact_gpio_responder.sv - GPIO factorial coprocessor: n + GO in, n! with DONE/ERR/BUSY out
// Counts k down from n, multiplying acc by k each pass; 4-phase GO/DONE handshake.
module fact_gpio_responder
  import fact_gpio_responder_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int RES_W  = RES_W_DEF,
  parameter int GO_BIT = GO_BIT_DEF
) (
  input logic                  clk,
  input logic                  rst,
  fact_gpio_responder_if.slave gp
);

  state_e           state_q;
  logic             go_q, done_q, err_q, busy_q;
  logic [RES_W-1:0] acc_q, result_q;
  logic [CNT_W-1:0] k_q;

  logic             go_d;
  logic [CNT_W-1:0] n_d;
  logic             mul_start_d;
  logic             mul_busy_unused, mul_valid, mul_ovf;
  logic [RES_W-1:0] mul_product;
  logic             unused_cmd_bits;

  assign go_d        = gp.gp_cmd[GO_BIT];
  assign n_d         = gp.gp_cmd[CNT_W-1:0];
  assign mul_start_d = (state_q == ST_EVAL) && go_d && (k_q > CNT_W'(1));

  mul_shift_add #(
    .RES_W (RES_W),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start_d),
    .a_i       (acc_q),
    .b_i       (k_q),
    .busy_o    (mul_busy_unused),
    .valid_o   (mul_valid),
    .product_o (mul_product),
    .ovf_o     (mul_ovf)
  );

  // go_q resets high so a GO level held across reset release is not seen as a rising edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      go_q     <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      k_q      <= '0;
    end else begin
      go_q <= go_d;
      case (state_q)
        ST_IDLE: begin
          if (go_d && !go_q) begin
            k_q     <= n_d;
            acc_q   <= RES_W'(1);
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (!go_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (k_q <= CNT_W'(1)) begin
            result_q <= acc_q;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          // abort wins over a write-back landing on the same edge
          if (!go_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (mul_valid) begin
            if (mul_ovf) begin
              err_q    <= 1'b1;
              result_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              acc_q   <= mul_product;
              k_q     <= k_q - CNT_W'(1);
              state_q <= ST_EVAL;
            end
          end
        end
        ST_DONE: begin
          if (!go_d) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gp.gp_status    = pack_status(done_q, err_q, busy_q, RES_FIELD_W'(result_q));
  assign unused_cmd_bits = ^{gp.gp_cmd, mul_busy_unused};

endmodule

// File: tb/tb_fact_gpio_responder.sv
// tb/tb_fact_gpio_responder.sv - scoreboard bench for the factorial responder
module tb_fact_gpio_responder;

  localparam int CNT_W  = 4;
  localparam int RES_W  = 29;
  localparam int GO_BIT = 4;

  typedef struct {
    int          n;
    logic [28:0] res;
    bit          err;
    int          lat;
    int          start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic done_prev = 1'b0;

  fact_gpio_responder_if gp();

  fact_gpio_responder #(
    .CNT_W  (CNT_W),
    .RES_W  (RES_W),
    .GO_BIT (GO_BIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .gp  (gp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // n! by plain arithmetic, multiplying n, n-1, ... ; the job stops at the first product past RES_W bits
  function automatic exp_t model(input int n);
    exp_t   e;
    longint p;
    p       = 1;
    e.n     = n;
    e.res   = '0;
    e.err   = 1'b0;
    e.start = 0;
    e.lat   = (n <= 1) ? 1 : 1 + (n - 1) * (CNT_W + 1);
    for (int j = 1; j <= n - 1; j++) begin
      p = p * (n - j + 1);
      if (p >= (longint'(1) << RES_W)) begin
        e.err = 1'b1;
        e.lat = j * (CNT_W + 1);
        return e;
      end
    end
    e.res = 29'(p);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && gp.gp_status[31] && !done_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("result", gp.gp_status[28:0], e.res);
        check("err", gp.gp_status[30], e.err);
        check("busy_at_done", gp.gp_status[29], 0);
        check("latency", cyc - e.start, e.lat);
      end
    end
    done_prev = rst ? 1'b0 : gp.gp_status[31];
  end

  task automatic set_cmd(input int n, input bit go);
    logic [31:0] c;
    c            = $urandom;
    c[CNT_W-1:0] = n[CNT_W-1:0];
    c[GO_BIT]    = go;
    gp.gp_cmd    = c;
  endtask

  task automatic start_job(input int n, input bit expect_done);
    exp_t e;
    @(negedge clk);
    set_cmd(n, 1'b1);
    if (expect_done) begin
      e       = model(n);
      e.start = cyc + 1;
      sb.push_back(e);
    end
  endtask

  task automatic run_job(input int n, input int hold, output logic [31:0] at_done);
    int t;
    t = 0;
    start_job(n, 1'b1);
    @(negedge clk);
    while (!gp.gp_status[31] && t < 600) begin
      set_cmd($urandom_range(0, 15), 1'b1);
      @(negedge clk);
      t++;
    end
    if (!gp.gp_status[31]) check("done_timeout", 0, 1);
    at_done = gp.gp_status;
    repeat (hold) begin
      set_cmd($urandom_range(0, 15), 1'b1);
      @(negedge clk);
    end
    check("hold_stable", gp.gp_status, at_done);
    set_cmd($urandom_range(0, 15), 1'b0);
    @(negedge clk);
    check("done_clear", gp.gp_status[31], 0);
    check("busy_idle", gp.gp_status[29], 0);
    check("result_kept", gp.gp_status[28:0], at_done[28:0]);
  endtask

  task automatic abort_job(input int n, input int d);
    logic [28:0] prev;
    prev = gp.gp_status[28:0];
    start_job(n, 1'b0);
    repeat (d) begin
      @(negedge clk);
      set_cmd($urandom_range(0, 15), 1'b1);
    end
    check("busy_before_abort", gp.gp_status[29], 1);
    set_cmd($urandom_range(0, 15), 1'b0);
    @(negedge clk);
    check("abort_busy", gp.gp_status[29], 0);
    check("abort_done", gp.gp_status[31], 0);
    check("abort_err", gp.gp_status[30], 0);
    check("abort_result", gp.gp_status[28:0], prev);
    repeat (3) @(negedge clk);
  endtask

  initial begin : stimulus
    logic [31:0] st;
    exp_t        e;
    int          n;
    int          d;

    set_cmd(0, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_status", gp.gp_status, 0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      set_cmd($urandom_range(0, 15), 1'b1);
    end
    check("no_start_go_held", gp.gp_status, 0);
    set_cmd(0, 1'b0);
    @(negedge clk);

    run_job(5, 10, st);
    check("n5_result", st[28:0], 120);
    check("n5_err", st[30], 0);
    run_job(0, 2, st);
    check("n0_result", st[28:0], 1);
    run_job(1, 2, st);
    check("n1_result", st[28:0], 1);
    run_job(12, 3, st);
    check("n12_result", st[28:0], 29'h1C8CFC00);
    check("n12_err", st[30], 0);
    run_job(13, 1, st);
    check("n13_err", st[30], 1);
    check("n13_result", st[28:0], 0);

    run_job(5, 1, st);
    abort_job(10, 5);
    check("abort_keeps_120", gp.gp_status[28:0], 120);

    start_job(10, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid_job", gp.gp_status, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("no_start_after_reset", gp.gp_status, 0);
    set_cmd(0, 1'b0);
    @(negedge clk);
    run_job(6, 2, st);
    check("n6_result", st[28:0], 720);

    for (int i = 0; i < 12; i++) begin
      n = $urandom_range(0, 15);
      if (n >= 2 && $urandom_range(0, 3) == 0) begin
        e = model(n);
        d = $urandom_range(1, e.lat - 1);
        abort_job(n, d);
      end else begin
        run_job(n, $urandom_range(1, 5), st);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
